// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues PC-addressed reads to a fixed-latency instruction
// memory and buffers the address-tagged returns in a small FIFO for the decoder.
module instr_fetch #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int MEM_LAT = 2,
    parameter int DEPTH   = 4
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              pc_en,
    input  logic              flush,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_addr,
    output logic              instr_valid,
    input  logic              instr_ready
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    logic [MEM_LAT-1:0] tag_valid_q, tag_valid_d;
    logic [ADDR_W-1:0]  tag_addr_q  [MEM_LAT];
    logic [ADDR_W-1:0]  tag_addr_d  [MEM_LAT];
    logic [DATA_W-1:0]  fifo_data_q [DEPTH];
    logic [DATA_W-1:0]  fifo_data_d [DEPTH];
    logic [ADDR_W-1:0]  fifo_addr_q [DEPTH];
    logic [ADDR_W-1:0]  fifo_addr_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W:0]     inflight;
    logic               issue;
    logic               push;
    logic               pop;

    assign instr_valid = !RST && (count_q != '0);
    assign instr       = fifo_data_q[rd_ptr_q];
    assign instr_addr  = fifo_addr_q[rd_ptr_q];
    assign mem_rd      = issue;
    assign pc_en       = issue;
    assign mem_addr    = pc_addr;

    // Credits: buffered plus in-flight entries never exceed DEPTH, so every
    // returning read finds a free slot. Pops only free credit a cycle later.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_LAT; i++) begin
            inflight = inflight + (CNT_W + 1)'(tag_valid_q[i]);
        end
        issue = !RST && !flush && (({1'b0, count_q} + inflight) < DEPTH_C);
    end

    // NOTE: every _d gets its default first, so no branch leaves one unassigned and no latch is inferred.
    always_comb begin
        tag_valid_d = '0;
        tag_addr_d  = tag_addr_q;
        fifo_data_d = fifo_data_q;
        fifo_addr_d = fifo_addr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        push        = 1'b0;
        pop         = 1'b0;

        tag_valid_d[0] = issue;
        tag_addr_d[0]  = pc_addr;
        for (int i = 1; i < MEM_LAT; i++) begin
            tag_valid_d[i] = tag_valid_q[i-1];
            tag_addr_d[i]  = tag_addr_q[i-1];
        end

        if (RST) begin
            tag_valid_d = '0;
            count_d     = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            // NOTE: storage is reset too, so instr/instr_addr read 0 until the first push.
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data_d[i] = '0;
                fifo_addr_d[i] = '0;
            end
        end else if (flush) begin
            tag_valid_d = '0;
            count_d     = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
        end else begin
            push = tag_valid_q[MEM_LAT-1];
            pop  = instr_valid && instr_ready;
            if (push) begin
                fifo_data_d[wr_ptr_q] = mem_rdata;
                fifo_addr_d[wr_ptr_q] = tag_addr_q[MEM_LAT-1];
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (!push && pop) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // NOTE: state uses non-blocking assignment; the combinational next-state logic above uses blocking.
    always_ff @(posedge clk) begin
        tag_valid_q <= tag_valid_d;
        tag_addr_q  <= tag_addr_d;
        fifo_data_q <= fifo_data_d;
        fifo_addr_q <= fifo_addr_d;
        wr_ptr_q    <= wr_ptr_d;
        rd_ptr_q    <= rd_ptr_d;
        count_q     <= count_d;
    end

endmodule
